// File: rtl/iic_pkg.sv
// ---------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the I2C register-initialisation slice.
//   - One-hot state encoding of the init sequencer FSM.
//   - Configuration-table entry layout {reg_addr[15:0], wr_data[7:0]}.
//   - Command constants shared with the I2C register controller.
//   - Small helpers to split a table entry and size the delay counter.
// ---------------------------------------------------------------------------
package iic_pkg;

    // One-hot so every state decode is a single flop bit.
    typedef enum logic [7:0] {
        ST_IDLE      = 8'b0000_0001,
        ST_PWR_WAIT  = 8'b0000_0010,
        ST_FETCH     = 8'b0000_0100,
        ST_REQ       = 8'b0000_1000,
        ST_WAIT_DONE = 8'b0001_0000,
        ST_GAP       = 8'b0010_0000,
        ST_DONE      = 8'b0100_0000,
        ST_ERR       = 8'b1000_0000
    } state_e;

    // Table entry layout.
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 8;
    localparam int ENTRY_W        = ADDR_W + DATA_W;
    localparam int IDX_W          = 8;
    localparam int ENTRY_ADDR_LSB = DATA_W;
    localparam int ENTRY_ADDR_MSB = ENTRY_W - 1;
    localparam int ENTRY_DATA_MSB = DATA_W - 1;

    // Controller command constants: R/W bit of the device address byte and
    // the register-address width selector.
    localparam logic CMD_WRITE    = 1'b0;
    localparam logic CMD_READ     = 1'b1;
    localparam logic ADDR_MODE_8  = 1'b0;
    localparam logic ADDR_MODE_16 = 1'b1;

    // Register address of an entry; in 8-bit mode only the low address byte
    // is meaningful, so the upper byte is forced to zero.
    function automatic logic [ADDR_W-1:0] entry_addr(input logic [ENTRY_W-1:0] entry,
                                                     input logic               mode16);
        logic [ADDR_W-1:0] full;
        full = entry[ENTRY_ADDR_MSB:ENTRY_ADDR_LSB];
        if (mode16 == ADDR_MODE_16) begin
            return full;
        end
        return {{(ADDR_W-8){1'b0}}, full[7:0]};
    endfunction

    function automatic logic [DATA_W-1:0] entry_data(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_DATA_MSB:0];
    endfunction

    // Width able to hold max(a, b); never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/iic_dly_cnt.sv
// ---------------------------------------------------------------------------
// iic_dly_cnt
// Loadable saturating down-counter used for both the power-up wait and the
// inter-write gap.  A load takes priority over counting; once the count
// reaches zero it stays there, so it never wraps.
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset (count <= RST_VAL)
//   load_i      load load_val_i this clock
//   load_val_i  value to load
//   en_i        decrement this clock (ignored while loading or at zero)
//   expired_o   count is zero
// ---------------------------------------------------------------------------
module iic_dly_cnt
    import iic_pkg::*;
#(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/iic_init_seq.sv
// ---------------------------------------------------------------------------
// iic_init_seq
// Walks a configuration table of {reg_addr, wr_data} entries after reset (or
// on start) and issues one write request per entry to the I2C register
// controller, waiting for each to finish.  Ends in DONE (all written) or
// ERR (a write was NACKed).
// Optional feature macro: IIC_INIT_RETRY_EN -- when defined, a NACKed entry
// is re-attempted up to RETRY_MAX times before the sequence aborts.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse, restarts the sequence (honoured in DONE/ERR)
//   tbl_idx    table read index to the synchronous ROM
//   tbl_data   ROM word {reg_addr, wr_data}, valid one clock after tbl_idx
//   w_req      one-cycle write request
//   device_id  constant 8-bit write address
//   reg_addr   register address of the current entry
//   addr_mode  constant: 1 = 16-bit register address, 0 = 8-bit
//   wr_data    data byte of the current entry
//   wr_done    one-cycle completion pulse from the controller
//   ack        1 = the write was NACKed (valid with wr_done)
//   busy       sequence in progress
//   init_done  all entries written without error
//   init_err   sequence aborted on a NACK
//   err_idx    index of the failing entry
// ---------------------------------------------------------------------------
module iic_init_seq
    import iic_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [7:0] DEVICE_ID = 8'h78,
    parameter logic       ADDR_MODE = 1'b1,
    parameter int         PWR_DLY   = 1000,
    parameter int         GAP_DLY   = 16,
    parameter int         RETRY_MAX = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [IDX_W-1:0]   tbl_idx,
    input  logic [ENTRY_W-1:0] tbl_data,
    output logic               w_req,
    output logic [7:0]         device_id,
    output logic [ADDR_W-1:0]  reg_addr,
    output logic               addr_mode,
    output logic [DATA_W-1:0]  wr_data,
    input  logic               wr_done,
    input  logic               ack,
    output logic               busy,
    output logic               init_done,
    output logic               init_err,
    output logic [IDX_W-1:0]   err_idx
);

    localparam int CNT_W = cnt_width(PWR_DLY, GAP_DLY);

    // A wait state occupies exactly N clocks: it is entered with N-1 loaded
    // and leaves on the clock that finds the counter at zero.
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'((PWR_DLY > 0) ? PWR_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_DLY > 0) ? GAP_DLY - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e              state_q;
    logic                fetch_2nd_q;
    logic [IDX_W-1:0]    tbl_idx_q;
    logic                w_req_q;
    logic [ADDR_W-1:0]   reg_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                busy_q;
    logic                init_done_q;
    logic                init_err_q;
    logic [IDX_W-1:0]    err_idx_q;

`ifdef IIC_INIT_RETRY_EN
    localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(RETRY_MAX);

    logic [RETRY_W-1:0]  retry_q;
    logic                retry_pend_q;
`endif

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_load_val;
    logic                cnt_en;
    logic                cnt_expired;

    // The counter is loaded on the clock that enters a wait state, so it is
    // already primed when the wait starts; the reset value primes the
    // power-up wait that follows reset release.
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = PWR_LOAD;
        if ((state_q == ST_WAIT_DONE) && wr_done) begin
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
        end else if (((state_q == ST_DONE) || (state_q == ST_ERR) || (state_q == ST_IDLE)) && start) begin
            cnt_load     = 1'b1;
            cnt_load_val = PWR_LOAD;
        end
        cnt_en = (state_q == ST_PWR_WAIT) || (state_q == ST_GAP);
    end

    iic_dly_cnt #(
        .W       (CNT_W),
        .RST_VAL (PWR_LOAD)
    ) u_dly_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .expired_o  (cnt_expired)
    );

    // Sequencer FSM.  Every output is a flop updated on the transition into
    // the state that owns it, so outputs change exactly with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_PWR_WAIT;
            fetch_2nd_q <= 1'b0;
            tbl_idx_q   <= '0;
            w_req_q     <= 1'b0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
            err_idx_q   <= '0;
`ifdef IIC_INIT_RETRY_EN
            retry_q      <= '0;
            retry_pend_q <= 1'b0;
`endif
        end else begin
            w_req_q <= 1'b0;
            unique case (state_q)
                ST_PWR_WAIT: begin
                    busy_q      <= 1'b1;
                    init_done_q <= 1'b0;
                    init_err_q  <= 1'b0;
                    tbl_idx_q   <= '0;
                    if (cnt_expired) begin
                        state_q <= ST_FETCH;
                    end
                end

                // First clock lets the ROM present the word for tbl_idx;
                // second clock captures it and raises the request.
                ST_FETCH: begin
                    if (!fetch_2nd_q) begin
                        fetch_2nd_q <= 1'b1;
                    end else begin
                        fetch_2nd_q <= 1'b0;
                        reg_addr_q  <= entry_addr(tbl_data, ADDR_MODE);
                        wr_data_q   <= entry_data(tbl_data);
                        w_req_q     <= 1'b1;
                        state_q     <= ST_REQ;
                    end
                end

                ST_REQ: begin
                    state_q <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (wr_done) begin
                        if (!ack) begin
                            state_q <= ST_GAP;
                        end else begin
`ifdef IIC_INIT_RETRY_EN
                            if (retry_q < RETRY_LIMIT) begin
                                retry_q      <= retry_q + RETRY_W'(1);
                                retry_pend_q <= 1'b1;
                                state_q      <= ST_GAP;
                            end else begin
                                err_idx_q  <= tbl_idx_q;
                                init_err_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= ST_ERR;
                            end
`else
                            err_idx_q  <= tbl_idx_q;
                            init_err_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= ST_ERR;
`endif
                        end
                    end
                end

                // A pending retry re-fetches the same index; otherwise the
                // sequence advances or finishes.
                ST_GAP: begin
                    if (cnt_expired) begin
`ifdef IIC_INIT_RETRY_EN
                        if (retry_pend_q) begin
                            retry_pend_q <= 1'b0;
                            state_q      <= ST_FETCH;
                        end else
`endif
                        if (tbl_idx_q == LAST_IDX) begin
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            tbl_idx_q <= tbl_idx_q + IDX_W'(1);
                            state_q   <= ST_FETCH;
`ifdef IIC_INIT_RETRY_EN
                            retry_q   <= '0;
`endif
                        end
                    end
                end

                // Terminal states; only here can start relaunch the sequence,
                // so a bus transaction is never abandoned.
                ST_DONE, ST_ERR, ST_IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        init_done_q <= 1'b0;
                        init_err_q  <= 1'b0;
                        tbl_idx_q   <= '0;
                        state_q     <= ST_PWR_WAIT;
`ifdef IIC_INIT_RETRY_EN
                        retry_q      <= '0;
                        retry_pend_q <= 1'b0;
`endif
                    end
                end

                // Illegal encodings park in IDLE, which waits for start.
                default: begin
                    fetch_2nd_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign tbl_idx   = tbl_idx_q;
    assign w_req     = w_req_q;
    assign device_id = {DEVICE_ID[7:1], CMD_WRITE};
    assign reg_addr  = reg_addr_q;
    assign addr_mode = ADDR_MODE;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign init_err  = init_err_q;
    assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_iic_init_seq.sv
// ---------------------------------------------------------------------------
// tb_iic_init_seq
// Directed bench for iic_init_seq: three-entry table, PWR_DLY=10, GAP_DLY=4,
// with a controller model that answers each request 20 clocks later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_iic_init_seq;

    localparam int CTRL_LAT = 20;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  tbl_idx;
    logic [23:0] tbl_data;
    logic        w_req;
    logic [7:0]  device_id;
    logic [15:0] reg_addr;
    logic        addr_mode;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        ack;
    logic        busy;
    logic        init_done;
    logic        init_err;
    logic [7:0]  err_idx;

    int checks;
    int errors;
    int cyc;
    int relCyc;
    int startCyc;

    // Request log filled by the controller model.
    int          reqCount;
    int          reqCyc  [32];
    logic [7:0]  reqIdx  [32];
    logic [15:0] reqAddr [32];
    logic [7:0]  reqData [32];
    int          stabErr;
    int          nackEntry;
    int          nackLeft;

    logic [23:0] rom    [0:3];
    logic [15:0] expAddr[0:2];
    logic [7:0]  expData[0:2];

    iic_init_seq #(
        .NUM_REGS  (3),
        .DEVICE_ID (8'h78),
        .ADDR_MODE (1'b1),
        .PWR_DLY   (10),
        .GAP_DLY   (4),
        .RETRY_MAX (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tbl_idx   (tbl_idx),
        .tbl_data  (tbl_data),
        .w_req     (w_req),
        .device_id (device_id),
        .reg_addr  (reg_addr),
        .addr_mode (addr_mode),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .ack       (ack),
        .busy      (busy),
        .init_done (init_done),
        .init_err  (init_err),
        .err_idx   (err_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Synchronous configuration ROM.
    initial begin
        rom[0] = 24'h1234_56;
        rom[1] = 24'h3008_82;
        rom[2] = 24'hABCD_EF;
        rom[3] = 24'h0000_00;
        expAddr[0] = 16'h1234; expData[0] = 8'h56;
        expAddr[1] = 16'h3008; expData[1] = 8'h82;
        expAddr[2] = 16'hABCD; expData[2] = 8'hEF;
    end

    always @(posedge clk) tbl_data <= rom[tbl_idx[1:0]];

    // Controller model: logs each request, checks the request fields stay
    // put, and answers CTRL_LAT clocks later, NACKing nackEntry nackLeft times.
    initial begin
        bit          pending;
        int          dcnt;
        logic [7:0]  capIdx;
        logic [15:0] capAddr;
        logic [7:0]  capData;
        pending = 0;
        dcnt    = 0;
        capIdx  = '0;
        capAddr = '0;
        capData = '0;
        wr_done = 1'b0;
        ack     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            wr_done = 1'b0;
            ack     = 1'b0;
            if (!rst_n) begin
                pending = 0;
                continue;
            end
            if (pending) begin
                if (reg_addr !== capAddr || wr_data !== capData ||
                    device_id !== 8'h78 || addr_mode !== 1'b1) begin
                    stabErr++;
                end
                dcnt--;
                if (dcnt == 0) begin
                    pending = 0;
                    wr_done = 1'b1;
                    if ((int'(capIdx) == nackEntry) && (nackLeft > 0)) begin
                        ack = 1'b1;
                        nackLeft--;
                    end
                end
            end
            if (w_req === 1'b1) begin
                if (reqCount < 32) begin
                    reqCyc[reqCount]  = cyc;
                    reqIdx[reqCount]  = tbl_idx;
                    reqAddr[reqCount] = reg_addr;
                    reqData[reqCount] = wr_data;
                end
                reqCount++;
                pending = 1;
                dcnt    = CTRL_LAT;
                capIdx  = tbl_idx;
                capAddr = reg_addr;
                capData = wr_data;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic reset_log();
        reqCount = 0;
        stabErr  = 0;
    endtask

    task automatic wait_finish(input int maxCycles, output bit ok);
        ok = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if ((init_done === 1'b1 || init_err === 1'b1) && busy === 1'b0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tbl_idx   !== 8'h00)  begin errors++; $display("[TB] FAIL rst_tbl_idx got %h want 00", tbl_idx); end
        checks++; if (w_req     !== 1'b0)   begin errors++; $display("[TB] FAIL rst_w_req got %b want 0", w_req); end
        checks++; if (reg_addr  !== 16'h0)  begin errors++; $display("[TB] FAIL rst_reg_addr got %h want 0000", reg_addr); end
        checks++; if (wr_data   !== 8'h00)  begin errors++; $display("[TB] FAIL rst_wr_data got %h want 00", wr_data); end
        checks++; if (busy      !== 1'b0)   begin errors++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        checks++; if (init_done !== 1'b0)   begin errors++; $display("[TB] FAIL rst_init_done got %b want 0", init_done); end
        checks++; if (init_err  !== 1'b0)   begin errors++; $display("[TB] FAIL rst_init_err got %b want 0", init_err); end
        checks++; if (err_idx   !== 8'h00)  begin errors++; $display("[TB] FAIL rst_err_idx got %h want 00", err_idx); end
        checks++; if (device_id !== 8'h78)  begin errors++; $display("[TB] FAIL device_id got %h want 78", device_id); end
        checks++; if (addr_mode !== 1'b1)   begin errors++; $display("[TB] FAIL addr_mode got %b want 1", addr_mode); end
        reset_log();
        rst_n  = 1'b1;
        relCyc = cyc;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL pwr_busy got %b want 1", busy); end
    endtask

    task automatic test_power_up();
        bit ok;
        wait_finish(2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL pwr_timeout got busy=%b want finished", busy); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL pwr_init_done got %b want 1", init_done); end
        checks++; if (init_err  !== 1'b0) begin errors++; $display("[TB] FAIL pwr_init_err got %b want 0", init_err); end
        checks++; if (busy      !== 1'b0) begin errors++; $display("[TB] FAIL pwr_busy_end got %b want 0", busy); end
        checks++; if (reqCount  != 3)     begin errors++; $display("[TB] FAIL pwr_req_count got %0d want 3", reqCount); end
        checks++; if (reqCyc[0] - relCyc != 12) begin errors++; $display("[TB] FAIL pwr_first_req got %0d want 12", reqCyc[0] - relCyc); end
        checks++; if (reqCyc[1] - reqCyc[0] != CTRL_LAT + 4 + 3) begin errors++; $display("[TB] FAIL pwr_spacing01 got %0d want 27", reqCyc[1] - reqCyc[0]); end
        checks++; if (reqCyc[2] - reqCyc[1] != CTRL_LAT + 4 + 3) begin errors++; $display("[TB] FAIL pwr_spacing12 got %0d want 27", reqCyc[2] - reqCyc[1]); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (reqIdx[i]  !== 8'(i))      begin errors++; $display("[TB] FAIL pwr_idx%0d got %h want %h", i, reqIdx[i], 8'(i)); end
            checks++; if (reqAddr[i] !== expAddr[i]) begin errors++; $display("[TB] FAIL pwr_addr%0d got %h want %h", i, reqAddr[i], expAddr[i]); end
            checks++; if (reqData[i] !== expData[i]) begin errors++; $display("[TB] FAIL pwr_data%0d got %h want %h", i, reqData[i], expData[i]); end
        end
        checks++; if (reqAddr[1] !== 16'h3008 || reqData[1] !== 8'h82) begin errors++; $display("[TB] FAIL entry1 got %h/%h want 3008/82", reqAddr[1], reqData[1]); end
        checks++; if (stabErr != 0) begin errors++; $display("[TB] FAIL pwr_stable got %0d changes want 0", stabErr); end
    endtask

    task automatic test_restart();
        bit ok;
        reset_log();
        pulse_start();
        checks++; if (busy      !== 1'b1)  begin errors++; $display("[TB] FAIL rs_busy got %b want 1", busy); end
        checks++; if (init_done !== 1'b0)  begin errors++; $display("[TB] FAIL rs_init_done got %b want 0", init_done); end
        checks++; if (tbl_idx   !== 8'h00) begin errors++; $display("[TB] FAIL rs_tbl_idx got %h want 00", tbl_idx); end
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (reqCount >= 1) begin ok = 1; break; end
        end
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rs_first_req got none want request"); end
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_finish(2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rs_timeout got busy=%b want finished", busy); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL rs_done got %b want 1", init_done); end
        checks++; if (reqCount != 3) begin errors++; $display("[TB] FAIL rs_req_count got %0d want 3", reqCount); end
        checks++; if (reqCyc[0] - startCyc != 13) begin errors++; $display("[TB] FAIL rs_latency got %0d want 13", reqCyc[0] - startCyc); end
        checks++; if (reqIdx[1] !== 8'h01 || reqIdx[2] !== 8'h02) begin errors++; $display("[TB] FAIL rs_order got %h,%h want 01,02", reqIdx[1], reqIdx[2]); end
    endtask

    task automatic test_nack();
        bit ok;
        int expReqs;
`ifdef IIC_INIT_RETRY_EN
        expReqs  = 4;
        nackLeft = 99;
`else
        expReqs  = 2;
        nackLeft = 1;
`endif
        nackEntry = 1;
        reset_log();
        pulse_start();
        wait_finish(2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL nack_timeout got busy=%b want finished", busy); end
        checks++; if (init_err  !== 1'b1)  begin errors++; $display("[TB] FAIL nack_init_err got %b want 1", init_err); end
        checks++; if (init_done !== 1'b0)  begin errors++; $display("[TB] FAIL nack_init_done got %b want 0", init_done); end
        checks++; if (err_idx   !== 8'h01) begin errors++; $display("[TB] FAIL nack_err_idx got %h want 01", err_idx); end
        checks++; if (busy      !== 1'b0)  begin errors++; $display("[TB] FAIL nack_busy got %b want 0", busy); end
        checks++; if (reqCount != expReqs) begin errors++; $display("[TB] FAIL nack_req_count got %0d want %0d", reqCount, expReqs); end
        nackLeft  = 0;
        nackEntry = -1;
        repeat (5) @(negedge clk);
        checks++; if (init_err !== 1'b1) begin errors++; $display("[TB] FAIL nack_hold got %b want 1", init_err); end
    endtask

`ifdef IIC_INIT_RETRY_EN
    task automatic test_retry();
        bit ok;
        nackEntry = 0;
        nackLeft  = 2;
        reset_log();
        pulse_start();
        checks++; if (init_err !== 1'b0) begin errors++; $display("[TB] FAIL rt_clear_err got %b want 0", init_err); end
        wait_finish(3000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rt_timeout got busy=%b want finished", busy); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL rt_done got %b want 1", init_done); end
        checks++; if (reqCount != 5) begin errors++; $display("[TB] FAIL rt_req_count got %0d want 5", reqCount); end
        checks++; if (reqIdx[0] !== 8'h00 || reqIdx[1] !== 8'h00 || reqIdx[2] !== 8'h00 || reqIdx[3] !== 8'h01)
            begin errors++; $display("[TB] FAIL rt_order got %h,%h,%h,%h want 00,00,00,01", reqIdx[0], reqIdx[1], reqIdx[2], reqIdx[3]); end
        checks++; if (reqCyc[1] - reqCyc[0] != CTRL_LAT + 4 + 3) begin errors++; $display("[TB] FAIL rt_spacing got %0d want 27", reqCyc[1] - reqCyc[0]); end
        nackLeft  = 0;
        nackEntry = -1;
    endtask
`endif

    task automatic test_reset_in_gap();
        bit ok;
        int seen;
        reset_log();
        pulse_start();
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (wr_done === 1'b1) seen++;
            if (seen == 2) break;
        end
        checks++; if (seen != 2) begin errors++; $display("[TB] FAIL gap_wr_done got %0d pulses want 2", seen); end
        @(negedge clk);
        checks++; if (tbl_idx !== 8'h01 || busy !== 1'b1) begin errors++; $display("[TB] FAIL gap_state got idx=%h busy=%b want 01/1", tbl_idx, busy); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (tbl_idx   !== 8'h00)  begin errors++; $display("[TB] FAIL gr_tbl_idx got %h want 00", tbl_idx); end
        checks++; if (w_req     !== 1'b0)   begin errors++; $display("[TB] FAIL gr_w_req got %b want 0", w_req); end
        checks++; if (reg_addr  !== 16'h0)  begin errors++; $display("[TB] FAIL gr_reg_addr got %h want 0000", reg_addr); end
        checks++; if (wr_data   !== 8'h00)  begin errors++; $display("[TB] FAIL gr_wr_data got %h want 00", wr_data); end
        checks++; if (busy      !== 1'b0)   begin errors++; $display("[TB] FAIL gr_busy got %b want 0", busy); end
        checks++; if (init_done !== 1'b0)   begin errors++; $display("[TB] FAIL gr_init_done got %b want 0", init_done); end
        checks++; if (init_err  !== 1'b0)   begin errors++; $display("[TB] FAIL gr_init_err got %b want 0", init_err); end
        checks++; if (err_idx   !== 8'h00)  begin errors++; $display("[TB] FAIL gr_err_idx got %h want 00", err_idx); end
        reset_log();
        rst_n  = 1'b1;
        relCyc = cyc;
        wait_finish(2000, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL gr_timeout got busy=%b want finished", busy); end
        checks++; if (init_done !== 1'b1) begin errors++; $display("[TB] FAIL gr_done got %b want 1", init_done); end
        checks++; if (reqCount != 3) begin errors++; $display("[TB] FAIL gr_req_count got %0d want 3", reqCount); end
        checks++; if (reqCyc[0] - relCyc != 12) begin errors++; $display("[TB] FAIL gr_first_req got %0d want 12", reqCyc[0] - relCyc); end
        checks++; if (reqIdx[0] !== 8'h00) begin errors++; $display("[TB] FAIL gr_first_idx got %h want 00", reqIdx[0]); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reqCount  = 0;
        stabErr   = 0;
        nackEntry = -1;
        nackLeft  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        test_reset();
        test_power_up();
        test_restart();
        test_nack();
`ifdef IIC_INIT_RETRY_EN
        test_retry();
`endif
        test_reset_in_gap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
